baud_gen_nco: RTL and testbench
===============================

Name: baud_gen_nco

Overview:
- Fractional (phase-accumulator) baud generator for the DE2-115 UART path.
- Produces a coherent pair of single-cycle strobes from one clock: `rx_tick` at OVERSAMPLE×baud for receiver sampling, and `tx_tick` at baud for the transmitter.
- Baud is runtime-programmable through an increment word, so rounding error no longer grows with the integer divisor.
- Drives the UART Tx/Rx pair feeding the counter/DRAM datapath.

Parameters:
- CLK_HZ, 50000000, input clock frequency. Used only to compute the default increment.
- BAUD_DEFAULT, 115200, baud rate loaded at reset.
- OVERSAMPLE, 16, rx ticks per bit. Power of two, at least 2.
- ACC_WIDTH, 24, phase accumulator width in bits.
- INC_DEFAULT, round(BAUD_DEFAULT*OVERSAMPLE*2^ACC_WIDTH/CLK_HZ) = 618475, reset increment.

Ports:
- clk_slow  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = accumulate; 0 = freeze all state, ticks forced to 0.
- inc_in  in  ACC_WIDTH  new increment value.
- inc_load  in  1  single-cycle strobe: capture inc_in and restart phase.
- rx_tick  out  1  one-cycle strobe at OVERSAMPLE×baud.
- tx_tick  out  1  one-cycle strobe at baud, coincident with every OVERSAMPLEth rx_tick.
- os_phase  out  log2(OVERSAMPLE)  current oversample index within the bit, 0..OVERSAMPLE-1.

Behaviour:
- State:
  - inc_q[ACC_WIDTH-1:0], reset to INC_DEFAULT.
  - acc[ACC_WIDTH-1:0], reset to 0.
  - os_cnt[log2(OVERSAMPLE)-1:0], reset to 0.
  - rx_tick and tx_tick are registered, reset to 0.
  - os_phase = os_cnt, reset to 0.
- Each clk_slow edge, with no load and enable=1:
  - {carry, acc} <= acc + inc_q, an (ACC_WIDTH+1)-bit sum. The wrap is modulo 2^ACC_WIDTH.
  - rx_tick <= carry.
  - If carry: os_cnt <= os_cnt+1, modulo OVERSAMPLE.
  - tx_tick <= carry AND (os_cnt == OVERSAMPLE-1).
- Latency: a tick is high during the cycle immediately after the edge on which the accumulator wraps. It lasts exactly 1 cycle.
- Average rx period = 2^ACC_WIDTH/inc_q cycles. Instantaneous period is floor or ceil of that value, never other.
- Default rates:
  - rx period 27.126 cycles (27 or 28).
  - tx period 434.03 cycles average.
  - Baud error < 0.01%.
- enable=0:
  - acc and os_cnt hold.
  - rx_tick <= 0, tx_tick <= 0.
  - On re-enable, counting resumes from the held phase.
- inc_load=1 (highest priority, acts regardless of enable):
  - inc_q <= inc_in, acc <= 0, os_cnt <= 0.
  - rx_tick <= 0, tx_tick <= 0.
  - The first wrap occurs ceil(2^ACC_WIDTH/inc_in) edges after the load edge.
- inc_q = 0: no ticks ever. Legal, used as a "stop" setting.
- inc_q = 2^ACC_WIDTH-1: a wrap on every edge except once per 2^ACC_WIDTH cycles.
- No glitch path: both ticks come straight from flops.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous), including any tick currently high.
- Reset deassertion is externally synchronised; the block requires no internal handling.

Optional Feature:
- Macro: BAUD_NCO_RESYNC_EN.
- Defined: adds input port `resync` (1 bit), driven by the Rx start-bit falling-edge detector.
  - On resync=1 (without inc_load): acc <= 2^(ACC_WIDTH-1), os_cnt <= OVERSAMPLE/2, ticks <= 0.
  - This centres subsequent rx_tick sampling and aligns tx_tick half a bit later.
  - inc_load has priority over resync.
  - resync acts even when enable=0.
- Undefined: no resync port, and none of the associated logic is generated.

Test Plan:
- Reset release with defaults, enable=1, 10000 cycles:
  - Every rx period is 27 or 28 cycles.
  - The count of rx_ticks is 368 ±1.
  - Every tx period is 434 or 435 cycles.
  - Each tx_tick coincides with an rx_tick at os_phase transition 15→0.
- inc_load with inc_in=0x400000 (2^22):
  - rx_tick first high in the cycle after the 4th edge post-load, then exactly every 4 cycles.
  - tx_tick every 64 cycles, first one 64 cycles after the load.
- enable dropped for 37 cycles mid-bit (inc 2^22):
  - No ticks while enable=0.
  - Phase preserved: the next rx_tick arrives at 4 minus (edges already accumulated) cycles after re-enable.
- inc_load=1 with enable=0, inc_in=0:
  - inc_q=0 and no tick for 1000 cycles after enable=1.
  - Reload with 0x400000 restores 4-cycle ticks.
- rst pulsed while rx_tick=1 and os_cnt=9:
  - Outputs drop to 0 without waiting for a clock edge.
  - os_phase=0 and inc_q=618475 after release.
- (BAUD_NCO_RESYNC_EN) inc 2^22, resync pulse:
  - First rx_tick 2 cycles later.
  - tx_tick on the 8th rx_tick after resync.
  - A simultaneous inc_load overrides the resync (acc=0, os_cnt=0).

Source files
------------

// File: rtl/baud_gen_nco.sv
// -----------------------------------------------------------------------------
// baud_gen_nco
// -----------------------------------------------------------------------------
// Fractional (phase-accumulator) baud generator for the UART Tx/Rx pair.
//
// A phase accumulator of ACC_WIDTH bits is advanced by a programmable
// increment every enabled clock. Each time it wraps, rx_tick pulses for one
// cycle. Every OVERSAMPLE-th wrap also pulses tx_tick. The average rx period
// is 2^ACC_WIDTH / inc cycles. Any single period is the floor or the ceiling
// of that value, so the rounding error does not grow with the divisor.
//
// Parameters
//   CLK_HZ        input clock frequency; only used to derive INC_DEFAULT
//   BAUD_DEFAULT  baud rate selected out of reset
//   OVERSAMPLE    rx ticks per bit (power of two, >= 2)
//   ACC_WIDTH     phase accumulator width
//   INC_DEFAULT   increment loaded at reset; rounded from the three above
//
// Ports
//   clk_slow  in   system clock
//   rst       in   asynchronous reset, active-high
//   enable    in   1 = accumulate, 0 = hold phase with both ticks low
//   inc_in    in   new increment word (ACC_WIDTH bits)
//   inc_load  in   strobe: take inc_in and restart phase; highest priority
//   resync    in   (only with BAUD_NCO_RESYNC_EN) move phase to mid-bit
//   rx_tick   out  one-cycle strobe at OVERSAMPLE x baud
//   tx_tick   out  one-cycle strobe at baud, always coincident with rx_tick
//   os_phase  out  oversample index within the current bit
//
// Optional feature
//   Define BAUD_NCO_RESYNC_EN to add the resync input. Without the macro the
//   port and its logic are not generated.
// -----------------------------------------------------------------------------
module baud_gen_nco #(
   parameter int     CLK_HZ       = 50000000,
   parameter int     BAUD_DEFAULT = 115200,
   parameter int     OVERSAMPLE   = 16,
   parameter int     ACC_WIDTH    = 24,
   parameter longint INC_DEFAULT  =
      (((longint'(BAUD_DEFAULT) * longint'(OVERSAMPLE)) << ACC_WIDTH)
       + longint'(CLK_HZ) / 2) / longint'(CLK_HZ),
   localparam int    OS_W         = $clog2(OVERSAMPLE)
) (
   input  logic                 clk_slow,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [ACC_WIDTH-1:0] inc_in,
   input  logic                 inc_load,
`ifdef BAUD_NCO_RESYNC_EN
   input  logic                 resync,
`endif
   output logic                 rx_tick,
   output logic                 tx_tick,
   output logic [OS_W-1:0]      os_phase
);

   localparam logic [ACC_WIDTH-1:0] INC_RST  = ACC_WIDTH'(INC_DEFAULT);
   localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
`ifdef BAUD_NCO_RESYNC_EN
   // Half a bit: the accumulator sits half-way to a wrap, and the oversample
   // counter sits half-way through the bit.
   localparam logic [ACC_WIDTH-1:0] ACC_HALF = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
   localparam logic [OS_W-1:0]      OS_HALF  = OS_W'(OVERSAMPLE / 2);
`endif

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] inc_reg,  inc_next;
   logic [ACC_WIDTH-1:0] acc_reg,  acc_next;
   logic [OS_W-1:0]      os_reg,   os_next;
   logic                 rx_reg,   rx_next;
   logic                 tx_reg,   tx_next;

   // ---------------------------------------------------------------------
   // Phase step. The extra top bit of the sum is the wrap (carry) flag;
   // the low bits are the new phase modulo 2^ACC_WIDTH.
   // ---------------------------------------------------------------------
   logic [ACC_WIDTH:0]   acc_sum;
   logic                 acc_carry;
   logic                 os_at_last;

   assign acc_sum    = {1'b0, acc_reg} + {1'b0, inc_reg};
   assign acc_carry  = acc_sum[ACC_WIDTH];
   assign os_at_last = (os_reg == OS_LAST);

   // ---------------------------------------------------------------------
   // Next-state logic. Priority: inc_load, then resync (if built), then
   // enable. In every case other than an enabled wrap the ticks are low,
   // so a tick can never last more than one cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      inc_next = inc_reg;
      acc_next = acc_reg;
      os_next  = os_reg;
      rx_next  = 1'b0;
      tx_next  = 1'b0;

      if (inc_load) begin
         inc_next = inc_in;
         acc_next = '0;
         os_next  = '0;
      end
`ifdef BAUD_NCO_RESYNC_EN
      else if (resync) begin
         acc_next = ACC_HALF;
         os_next  = OS_HALF;
      end
`endif
      else if (enable) begin
         acc_next = acc_sum[ACC_WIDTH-1:0];
         rx_next  = acc_carry;
         // OVERSAMPLE is a power of two, so the natural wrap of os_reg
         // gives the modulo-OVERSAMPLE count.
         if (acc_carry) begin
            os_next = os_reg + OS_W'(1);
         end
         // The bit boundary is the wrap that takes the index from the last
         // slot back to zero.
         tx_next  = acc_carry & os_at_last;
      end
   end

   // ---------------------------------------------------------------------
   // Registers. Both strobes come straight from flops, so downstream logic
   // sees no combinational glitch from the adder.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_slow or posedge rst) begin
      if (rst) begin
         inc_reg <= INC_RST;
         acc_reg <= '0;
         os_reg  <= '0;
         rx_reg  <= 1'b0;
         tx_reg  <= 1'b0;
      end else begin
         inc_reg <= inc_next;
         acc_reg <= acc_next;
         os_reg  <= os_next;
         rx_reg  <= rx_next;
         tx_reg  <= tx_next;
      end
   end

   assign rx_tick  = rx_reg;
   assign tx_tick  = tx_reg;
   assign os_phase = os_reg;

endmodule

// File: tb/tb_baud_gen_nco.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_nco
// Self-checking bench for baud_gen_nco. The reference model describes the
// generator by its phase arithmetic: after n enabled edges since a load the
// total phase is base + n*inc, the number of wraps is that value shifted down
// by ACC_WIDTH, and a tick is due whenever the wrap count moves.
// -----------------------------------------------------------------------------
module tb_baud_gen_nco;

   localparam int     W       = 24;
   localparam int     OS      = 16;
   localparam int     OSW     = 4;
   localparam longint INC_DEF = 618475;
   localparam logic [W-1:0] INC_Q22 = 24'h400000;

   logic           clk_slow = 1'b0;
   logic           rst      = 1'b0;
   logic           enable   = 1'b0;
   logic           inc_load = 1'b0;
   logic [W-1:0]   inc_in   = '0;
`ifdef BAUD_NCO_RESYNC_EN
   logic           resync   = 1'b0;
`endif
   logic           rx_tick;
   logic           tx_tick;
   logic [OSW-1:0] os_phase;

   int checks   = 0;
   int failures = 0;

   // reference model state
   longint         m_inc;
   longint         m_base;
   longint         m_n;
   longint         m_os0;
   logic           e_rx;
   logic           e_tx;
   logic [OSW-1:0] e_os;

   typedef struct {
      logic         en;
      logic         ld;
      logic [W-1:0] inc;
      logic         rx;
      logic         tx;
      logic [3:0]   os;
   } vec_t;

   always #5 clk_slow = ~clk_slow;

   baud_gen_nco #(
      .CLK_HZ      (50000000),
      .BAUD_DEFAULT(115200),
      .OVERSAMPLE  (OS),
      .ACC_WIDTH   (W)
   ) dut (
      .clk_slow(clk_slow),
      .rst     (rst),
      .enable  (enable),
      .inc_in  (inc_in),
      .inc_load(inc_load),
`ifdef BAUD_NCO_RESYNC_EN
      .resync  (resync),
`endif
      .rx_tick (rx_tick),
      .tx_tick (tx_tick),
      .os_phase(os_phase)
   );

   // ---------------------------------------------------------------------
   // Comparison helpers
   // ---------------------------------------------------------------------
   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic longint m_wraps(input longint n);
      return (m_base + n * m_inc) >> W;
   endfunction

   task automatic model_reset();
      m_inc  = INC_DEF;
      m_base = 0;
      m_n    = 0;
      m_os0  = 0;
   endtask

   // One clock: drive inputs, step the model, optionally compare.
   task automatic cyc(input logic en, input logic ld, input logic [W-1:0] inc,
                      input logic rs, input bit chk);
      longint w0;
      longint w1;
      enable   = en;
      inc_load = ld;
      inc_in   = inc;
`ifdef BAUD_NCO_RESYNC_EN
      resync   = rs;
`endif
      @(posedge clk_slow);
      #1;
      if (ld) begin
         m_inc = longint'(inc); m_base = 0; m_n = 0; m_os0 = 0;
         e_rx = 1'b0; e_tx = 1'b0;
      end else if (rs) begin
         m_base = longint'(1) << (W - 1); m_n = 0; m_os0 = OS / 2;
         e_rx = 1'b0; e_tx = 1'b0;
      end else if (en) begin
         w0 = m_wraps(m_n);
         m_n++;
         w1 = m_wraps(m_n);
         e_rx = (w1 != w0);
         e_tx = e_rx && (((m_os0 + w1) % OS) == 0);
      end else begin
         e_rx = 1'b0; e_tx = 1'b0;
      end
      e_os = OSW'((m_os0 + m_wraps(m_n)) % OS);
      if (chk) begin
         check_eq($sformatf("model rx/tx/os n=%0d", m_n),
                  {61'd0, rx_tick, tx_tick, os_phase[0]} | {56'd0, os_phase, 4'd0},
                  {61'd0, e_rx, e_tx, e_os[0]} | {56'd0, e_os, 4'd0});
      end
      inc_load = 1'b0;
`ifdef BAUD_NCO_RESYNC_EN
      resync   = 1'b0;
`endif
   endtask

   // Enabled edges until the next rx_tick (model-checked); -1 on timeout.
   task automatic edges_to_rx(output int n);
      n = -1;
      for (int i = 1; i <= 2000; i++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      enable   = 1'b0;
      inc_load = 1'b0;
      inc_in   = '0;
`ifdef BAUD_NCO_RESYNC_EN
      resync   = 1'b0;
`endif
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #2;
      check_eq("reset outputs", {rx_tick, tx_tick, os_phase}, 6'd0);
      @(posedge clk_slow);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------
   vec_t vecs[20];

   initial begin
      int n;
      int last_rx;
      int last_tx;
      int rx_cnt;
      int found;
      logic [OSW-1:0] prev_os;

      // inputs {en, ld, inc}, expected outputs after the edge {rx, tx, os}
      vecs[0]  = '{1'b0, 1'b1, INC_Q22,  1'b0, 1'b0, 4'd0};
      vecs[1]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[2]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[4]  = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 4'd1};
      vecs[5]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd1};
      vecs[6]  = '{1'b0, 1'b0, 24'h0,    1'b0, 1'b0, 4'd1};
      vecs[7]  = '{1'b0, 1'b0, 24'h0,    1'b0, 1'b0, 4'd1};
      vecs[8]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd1};
      vecs[9]  = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd1};
      vecs[10] = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 4'd2};
      vecs[11] = '{1'b1, 1'b1, INC_Q22,  1'b0, 1'b0, 4'd0};
      vecs[12] = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[13] = '{1'b0, 1'b1, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[14] = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[15] = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[16] = '{1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b0, 4'd0};
      vecs[17] = '{1'b1, 1'b0, 24'h0,    1'b0, 1'b0, 4'd0};
      vecs[18] = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 4'd1};
      vecs[19] = '{1'b1, 1'b0, 24'h0,    1'b1, 1'b0, 4'd2};

      // 1) defaults after reset, 10000 enabled cycles
      do_reset();
      last_rx = -1; last_tx = -1; rx_cnt = 0; prev_os = '0;
      for (int c = 1; c <= 10000; c++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick === 1'b1) begin
            rx_cnt++;
            if (last_rx < 0) check_eq("first rx edge after reset", 64'(c), 64'd28);
            else             check_range("rx period", c - last_rx, 27, 28);
            last_rx = c;
         end
         if (tx_tick === 1'b1) begin
            check_eq("tx with rx at 15->0", {rx_tick, prev_os, os_phase}, {1'b1, 4'd15, 4'd0});
            if (last_tx >= 0) check_range("tx period", c - last_tx, 434, 435);
            last_tx = c;
         end
         prev_os = os_phase;
      end
      check_range("rx count in 10000 cycles", rx_cnt, 367, 369);

      // 2) table: load 2^22, enable gaps, loads under enable=0, inc extremes
      do_reset();
      foreach (vecs[i]) begin
         enable   = vecs[i].en;
         inc_load = vecs[i].ld;
         inc_in   = vecs[i].inc;
         @(posedge clk_slow);
         #1;
         check_eq($sformatf("vector %0d", i), {rx_tick, tx_tick, os_phase},
                  {vecs[i].rx, vecs[i].tx, vecs[i].os});
      end
      inc_load = 1'b0;

      // 2b) load 2^22: rx every 4 edges, tx at 64 and 128
      do_reset();
      cyc(1'b1, 1'b1, INC_Q22, 1'b0, 1'b1);
      last_rx = -1; last_tx = -1;
      for (int c = 1; c <= 130; c++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick === 1'b1) begin
            if (last_rx < 0) check_eq("first rx after 2^22 load", 64'(c), 64'd4);
            else             check_eq("rx period 2^22", 64'(c - last_rx), 64'd4);
            last_rx = c;
         end
         if (tx_tick === 1'b1) begin
            check_eq("tx edge 2^22", 64'(c), 64'(last_tx < 0 ? 64 : last_tx + 64));
            last_tx = c;
         end
      end
      check_eq("tx seen after 2^22 load", 64'(last_tx), 64'd128);

      // 3) enable dropped for 37 cycles after 2 accumulated edges
      cyc(1'b1, 1'b1, INC_Q22, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      rx_cnt = 0;
      for (int c = 0; c < 37; c++) begin
         cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick !== 1'b0 || tx_tick !== 1'b0) rx_cnt++;
      end
      check_eq("ticks while disabled", 64'(rx_cnt), 64'd0);
      edges_to_rx(n);
      check_eq("rx after re-enable", 64'(n), 64'd2);

      // 4) load inc=0 while disabled: stop setting, then restore
      cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
      rx_cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick !== 1'b0 || tx_tick !== 1'b0) rx_cnt++;
      end
      check_eq("ticks with inc=0", 64'(rx_cnt), 64'd0);
      cyc(1'b1, 1'b1, INC_Q22, 1'b0, 1'b1);
      edges_to_rx(n);
      check_eq("rx after restore", 64'(n), 64'd4);
      edges_to_rx(n);
      check_eq("rx period after restore", 64'(n), 64'd4);

      // 5) asynchronous reset while rx_tick=1 and os_phase=9
      cyc(1'b1, 1'b1, INC_Q22, 1'b0, 1'b1);
      found = 0;
      for (int c = 0; c < 200; c++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (rx_tick === 1'b1 && os_phase === 4'd9) begin
            found = 1;
            break;
         end
      end
      check_eq("reached rx=1 os=9", 64'(found), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("async reset outputs", {rx_tick, tx_tick, os_phase}, 6'd0);
      #2;
      rst = 1'b0;
      model_reset();
      check_eq("os_phase after release", 64'(os_phase), 64'd0);
      edges_to_rx(n);
      check_eq("default inc after mid reset", 64'(n), 64'd28);

`ifdef BAUD_NCO_RESYNC_EN
      // 6) resync centring and load-over-resync priority
      cyc(1'b1, 1'b1, INC_Q22, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
      check_eq("os after resync", 64'(os_phase), 64'd8);
      edges_to_rx(n);
      check_eq("rx after resync", 64'(n), 64'd2);
      rx_cnt = 1;
      found = (tx_tick === 1'b1) ? 1 : 0;
      while (found == 0 && rx_cnt < 20) begin
         edges_to_rx(n);
         rx_cnt++;
         if (tx_tick === 1'b1) found = 1;
      end
      check_eq("tx on rx number after resync", 64'(rx_cnt), 64'd8);
      for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, INC_Q22, 1'b1, 1'b1);
      check_eq("load beats resync os", 64'(os_phase), 64'd0);
      edges_to_rx(n);
      check_eq("load beats resync phase", 64'(n), 64'd4);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check_eq("resync while disabled", 64'(os_phase), 64'd8);
`endif

      // 7) randomized traffic against the model
      do_reset();
      cyc(1'b1, 1'b1, W'($urandom_range(1 << 20, (1 << 24) - 1)), 1'b0, 1'b1);
      for (int c = 0; c < 4000; c++) begin
         logic         r_en;
         logic         r_ld;
         logic         r_rs;
         logic [W-1:0] r_inc;
         r_en  = ($urandom_range(0, 9) != 0);
         r_ld  = ($urandom_range(0, 199) == 0);
         r_rs  = 1'b0;
`ifdef BAUD_NCO_RESYNC_EN
         r_rs  = ($urandom_range(0, 149) == 0);
`endif
         case ($urandom_range(0, 7))
            0:       r_inc = '0;
            1:       r_inc = 24'hFFFFFF;
            default: r_inc = W'($urandom_range(1 << 20, (1 << 24) - 1));
         endcase
         cyc(r_en, r_ld, r_inc, r_rs, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case any wait above fails to return.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
